dac_sample_buffer: RTL
======================

DAC_SAMPLE_BUFFER -- requirements
Module: dac_sample_buffer

Interface
REQ-001 Parameters SHALL be: DW, 10, sample width matching the DAC input bus; DEPTH, 8, FIFO entries (power of two); RESET_CODE, 10'h200, DAC code held after reset (mid-scale).
REQ-002 CLK input 1: single system clock from the PLL; all state SHALL update on its rising edge.
REQ-003 reset input 1: synchronous, active-high; sampled on the rising edge of CLK only.
REQ-004 in_data input DW: sample from the core.
REQ-005 in_valid input 1: core offers in_data this cycle.
REQ-006 in_ready output 1: buffer accepts in_data this cycle.
REQ-007 enable input 1: sample playback enable.
REQ-008 div_val input 8: sample period is div_val+1 CLK cycles.
REQ-009 clr_underrun input 1: clears the underrun flag.
REQ-010 D output DW: registered code driven to the DAC D bus.
REQ-011 sample_strobe output 1: one-cycle pulse, high in the first cycle a new D value is presented.
REQ-012 underrun output 1: sticky flag, a tick found the FIFO empty.
REQ-013 level output 4: current FIFO occupancy, 0..DEPTH.

Function
REQ-014 A write SHALL occur when in_valid and in_ready are both 1 at a rising edge; in_ready SHALL equal (level != DEPTH) and not reset, with no same-cycle bypass when full.
REQ-015 The FIFO SHALL be circular with wrapping read and write pointers; level SHALL increment on write-only, decrement on pop-only, and stay unchanged on simultaneous write and pop.
REQ-016 The divider counter SHALL be 8 bits; while enable=0 it SHALL be held at 0 and no tick SHALL occur.
REQ-017 With enable=1, a tick SHALL occur in any cycle where counter >= div_val; on a tick the counter SHALL load 0, otherwise it SHALL increment.
REQ-018 div_val=0 SHALL produce a tick every cycle; a div_val decrease below the current count SHALL cause a tick in the next cycle.
REQ-019 On a tick with level>0, the head entry SHALL be popped and loaded into D at that edge, and sample_strobe SHALL be 1 for exactly the following cycle.
REQ-020 On a tick with level=0, D SHALL hold its value, sample_strobe SHALL stay 0, and underrun SHALL be set at that edge.
REQ-021 A sample written at edge k SHALL be poppable no earlier than a tick evaluated in the cycle after edge k; a write and a tick on the same edge with level=0 SHALL count as an underrun.
REQ-022 underrun SHALL stay set until clr_underrun=1 at an edge; if set and clear coincide, set SHALL win.
REQ-023 When enable falls, D SHALL hold its last value and FIFO contents SHALL be preserved; writes SHALL continue to be accepted.

Reset
REQ-024 With reset=1 at an edge: pointers, level and counter SHALL become 0; D SHALL become RESET_CODE; sample_strobe and underrun SHALL become 0; FIFO contents SHALL be discarded.
REQ-025 Reset asserted mid-operation SHALL take priority over any write, pop, tick or clear in that cycle.
REQ-026 While reset=1, in_ready SHALL be 0.

Verification
REQ-027 Reset: after one reset cycle -> D=10'h200, level=0, in_ready=1, underrun=0, sample_strobe=0.
REQ-028 Rate: enable=1, div_val=3, preload 10'h001..10'h004 -> D steps 1,2,3,4 exactly 4 cycles apart, with one strobe per step; then underrun=1 at the next tick and D=4 held.
REQ-029 Full: enable=0, offer 9 writes -> level=8, in_ready=0 on the 9th, and the 9th value is not stored.
REQ-030 Concurrency: level=4, write and tick on the same edge -> level stays 4, and the popped value is the oldest entry.
REQ-031 Wrap: 20 sequential writes/pops of values 0..19 with div_val=0 -> D outputs 0..19 in order, with no underrun while level>0.
REQ-032 Mid-op reset: reset asserted at level=5 during a tick -> next cycle level=0, D=10'h200, no strobe; clr_underrun and set coinciding -> underrun stays 1.

Source files
------------

// File: rtl/dac_sample_buffer.sv
// Sample FIFO feeding a DAC at a programmable rate: samples from the core are
// queued and popped into the registered D bus once every div_val+1 cycles.
module dac_sample_buffer #(
  parameter int unsigned    DW         = 10,
  parameter int unsigned    DEPTH      = 8,
  parameter logic [DW-1:0]  RESET_CODE = DW'(10'h200),
  localparam int unsigned   AW         = $clog2(DEPTH),
  localparam int unsigned   LW         = AW + 1
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          enable,
  input  logic [7:0]    div_val,
  input  logic          clr_underrun,
  output logic [DW-1:0] D,
  output logic          sample_strobe,
  output logic          underrun,
  output logic [LW-1:0] level
);

  localparam int unsigned CW = 8;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          tick;
  logic          wr;
  logic          pop;
  logic          empty;

  // No bypass: a full FIFO refuses the write even if a pop happens this edge.
  assign in_ready = !reset && (level != LW'(DEPTH));
  assign wr       = in_valid && in_ready;
  assign empty    = (level == '0);
  assign tick     = enable && (cnt >= div_val);
  assign pop      = tick && !empty;

  // Sample storage; contents are left as-is on reset, pointers make them stale.
  always_ff @(posedge CLK) begin
    if (wr) mem[wr_ptr] <= in_data;
  end

  // Sample-rate divider.
  always_ff @(posedge CLK) begin
    if (reset || !enable || tick) cnt <= '0;
    else                          cnt <= cnt + CW'(1);
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({wr, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // DAC output register, strobe and sticky underrun (set beats clear).
  always_ff @(posedge CLK) begin
    if (reset) begin
      D             <= RESET_CODE;
      sample_strobe <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      if (pop) D <= mem[rd_ptr];
      sample_strobe <= pop;
      if (tick && empty)     underrun <= 1'b1;
      else if (clr_underrun) underrun <= 1'b0;
    end
  end

endmodule
